cpu_mem_arbiter: RTL and testbench
==================================

# cpu_mem_arbiter

Two-master arbiter that shares the CPU's single Wishbone-style memory port between the instruction fetch unit and the load/store (data) unit. Data accesses get fixed priority, bounded by a starvation guard that forces a fetch grant after a run of data grants. A fetch transaction already on the bus can be cancelled by a pipeline flush (branch); its response is drained and discarded. The block sits between `cpu_fetch`/load-store and the external memory bus.

## Interface
Parameters:
- `MAX_DATA_RUN`, 4: max consecutive data grants while a fetch is pending (1..15).

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `f_req_i`  in  1  fetch request, level; held with `f_addr_i` until `f_ack_o` or flush.
- `f_addr_i`  in  32  fetch address (word aligned).
- `f_flush_i`  in  1  cancel the outstanding or pending fetch (branch taken).
- `f_ack_o`  out  1  one-cycle fetch completion pulse.
- `f_data_o`  out  32  fetch read data, valid with `f_ack_o`.
- `d_req_i`  in  1  data request, level; held with its qualifiers until `d_ack_o`.
- `d_we_i`  in  1  data write enable.
- `d_sel_i`  in  4  byte lane selects.
- `d_addr_i`  in  32  data address.
- `d_data_i`  in  32  write data.
- `d_ack_o`  out  1  one-cycle data completion pulse.
- `d_data_o`  out  32  data read data, valid with `d_ack_o`.
- `m_cyc_o`, `m_stb_o`  out  1 each  bus cycle / strobe.
- `m_we_o`  out  1  bus write enable.
- `m_sel_o`  out  4  bus byte selects (fetch: 4'hF).
- `m_addr_o`  out  32  bus address.
- `m_data_o`  out  32  bus write data.
- `m_data_i`  in  32  bus read data.
- `m_ack_i`  in  1  bus acknowledge.
- `grant_o`  out  2  current owner: 00 none, 01 fetch, 10 data.

## Operation
- States: IDLE, XFER_F, XFER_D, DISCARD, RESP.
- IDLE: if `d_req_i` and (`run_cnt` < `MAX_DATA_RUN` or `!f_req_i`) → XFER_D; else if `f_req_i` and `!f_flush_i` → XFER_F; else stay.
- Entering XFER_*: address/we/sel/wdata latched into bus registers; `m_cyc_o`=`m_stb_o`=1 until `m_ack_i`.
- XFER_F/XFER_D on `m_ack_i`: latch `m_data_i` into the owner's data register → RESP. Bus signals drop in RESP.
- RESP: pulse owner's ack for one cycle (suppressed if fetch and `f_flush_i`=1) → IDLE. RESP gives the requester one cycle to drop or change its request before re-arbitration.
- `f_flush_i` in XFER_F without `m_ack_i` → DISCARD; bus stays asserted (no bus abort). DISCARD on `m_ack_i` → IDLE, no `f_ack_o`. Flush in the same cycle as `m_ack_i` → RESP with ack suppressed.
- `run_cnt` (4 bits): +1 on each data grant while `f_req_i`=1, saturates at 15; cleared on fetch grant or whenever `f_req_i`=0 in IDLE.
- Simultaneous `d_req_i`/`f_req_i` with `run_cnt` at limit: fetch wins.
- `d_*` requests never flushed; a data transaction always completes.

## Timing
- Reset (async assert): state IDLE, `run_cnt`=0, all outputs 0. Mid-transaction reset drops `m_cyc_o`/`m_stb_o` immediately; the bus tolerates this.
- Request at cycle 0 in IDLE → `m_stb_o` at cycle 1. `m_ack_i` at cycle k → ack pulse at k+1 → IDLE at k+2. Minimum transaction, zero-wait-state bus: 3 cycles; throughput one access per 3 cycles.
- All outputs registered; no combinational path from any input to any output.
- `grant_o` reflects XFER/DISCARD/RESP ownership; 00 in IDLE.

## Structure
- Shared package `cpu_arb_pkg`: state encoding and `GRANT_NONE/FETCH/DATA` constants.
- Single module; no sub-module (counter and FSM are small).

## Test plan
- Fetch only, `m_ack_i` 2 cycles after strobe, addr 0x1000 → `m_addr_o`=0x1000, `m_sel_o`=F, `f_ack_o` pulse with bus data 0xDEADBEEF.
- Both request every cycle, `MAX_DATA_RUN`=4 → grant sequence D,D,D,D,F,D,D,D,D,F.
- Data write 0x12345678 to 0x2004, sel 4'b0011 → `m_we_o`=1, bus fields match, one `d_ack_o`.
- `f_flush_i` one cycle after fetch strobe, ack 3 cycles later → DISCARD, no `f_ack_o`, `m_stb_o` held until ack, then IDLE.
- Flush coincident with `m_ack_i` → RESP, `f_ack_o` stays 0.
- Reset deasserted→asserted mid-XFER_D → all outputs 0 immediately; after release, new fetch completes normally.

Source files
------------

// File: rtl/cpu_arb_pkg.sv
// rtl/cpu_arb_pkg.sv - state encoding and grant codes shared by the CPU memory arbiter
package cpu_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_XFER_F  = 3'd1,
        ST_XFER_D  = 3'd2,
        ST_DISCARD = 3'd3,
        ST_RESP    = 3'd4
    } arb_state_t;

    localparam logic [1:0] GRANT_NONE  = 2'b00;
    localparam logic [1:0] GRANT_FETCH = 2'b01;
    localparam logic [1:0] GRANT_DATA  = 2'b10;

endpackage

// File: rtl/cpu_mem_arbiter.sv
// rtl/cpu_mem_arbiter.sv - fetch/data arbiter for the CPU's single Wishbone-style memory port
module cpu_mem_arbiter
    import cpu_arb_pkg::*;
#(
    parameter int unsigned MAX_DATA_RUN = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        f_req_i,
    input  logic [31:0] f_addr_i,
    input  logic        f_flush_i,
    output logic        f_ack_o,
    output logic [31:0] f_data_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [3:0]  d_sel_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_data_i,
    output logic        d_ack_o,
    output logic [31:0] d_data_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [3:0]  m_sel_o,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_data_o,
    input  logic [31:0] m_data_i,
    input  logic        m_ack_i,
    output logic [1:0]  grant_o
);

    localparam logic [3:0] LP_RUN_LIMIT = 4'(MAX_DATA_RUN);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic [3:0] r_run_cnt;
    logic       w_grant_f;
    logic       w_grant_d;
    logic       w_ack_f;
    logic       w_ack_d;
    logic       w_bus_done;
    logic [1:0] w_grant_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_grant_f   = 1'b0;
        w_grant_d   = 1'b0;
        w_ack_f     = 1'b0;
        w_ack_d     = 1'b0;
        w_bus_done  = 1'b0;
        w_grant_nxt = GRANT_NONE;
        case (r_state)
            ST_IDLE: begin
                if (d_req_i && ((r_run_cnt < LP_RUN_LIMIT) || !f_req_i)) begin
                    w_state_nxt = ST_XFER_D;
                    w_grant_d   = 1'b1;
                end else if (f_req_i && !f_flush_i) begin
                    w_state_nxt = ST_XFER_F;
                    w_grant_f   = 1'b1;
                end
            end
            ST_XFER_F: begin
                if (m_ack_i) begin
                    w_state_nxt = ST_RESP;
                    w_ack_f     = !f_flush_i;
                    w_bus_done  = 1'b1;
                end else if (f_flush_i) begin
                    w_state_nxt = ST_DISCARD;
                end
            end
            ST_XFER_D: begin
                if (m_ack_i) begin
                    w_state_nxt = ST_RESP;
                    w_ack_d     = 1'b1;
                    w_bus_done  = 1'b1;
                end
            end
            ST_DISCARD: begin
                // The cancelled fetch stays on the bus until the slave answers.
                if (m_ack_i) begin
                    w_state_nxt = ST_IDLE;
                    w_bus_done  = 1'b1;
                end
            end
            ST_RESP:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        case (w_state_nxt)
            ST_XFER_F, ST_DISCARD: w_grant_nxt = GRANT_FETCH;
            ST_XFER_D:             w_grant_nxt = GRANT_DATA;
            ST_RESP:               w_grant_nxt = grant_o;
            default:               w_grant_nxt = GRANT_NONE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_run_cnt <= 4'd0;
        end else if (r_state == ST_IDLE) begin
            if (w_grant_f || !f_req_i) begin
                r_run_cnt <= 4'd0;
            end else if (w_grant_d && (r_run_cnt != 4'hF)) begin
                r_run_cnt <= r_run_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            f_ack_o  <= 1'b0;
            d_ack_o  <= 1'b0;
            f_data_o <= 32'd0;
            d_data_o <= 32'd0;
            m_cyc_o  <= 1'b0;
            m_stb_o  <= 1'b0;
            m_we_o   <= 1'b0;
            m_sel_o  <= 4'd0;
            m_addr_o <= 32'd0;
            m_data_o <= 32'd0;
            grant_o  <= GRANT_NONE;
        end else begin
            f_ack_o <= w_ack_f;
            d_ack_o <= w_ack_d;
            grant_o <= w_grant_nxt;
            if (w_grant_f) begin
                m_cyc_o  <= 1'b1;
                m_stb_o  <= 1'b1;
                m_we_o   <= 1'b0;
                m_sel_o  <= 4'hF;
                m_addr_o <= f_addr_i;
                m_data_o <= 32'd0;
            end else if (w_grant_d) begin
                m_cyc_o  <= 1'b1;
                m_stb_o  <= 1'b1;
                m_we_o   <= d_we_i;
                m_sel_o  <= d_sel_i;
                m_addr_o <= d_addr_i;
                m_data_o <= d_data_i;
            end else if (w_bus_done) begin
                m_cyc_o  <= 1'b0;
                m_stb_o  <= 1'b0;
                m_we_o   <= 1'b0;
                m_sel_o  <= 4'd0;
                m_addr_o <= 32'd0;
                m_data_o <= 32'd0;
            end
            if ((r_state == ST_XFER_F) && m_ack_i) begin
                f_data_o <= m_data_i;
            end
            if ((r_state == ST_XFER_D) && m_ack_i) begin
                d_data_o <= m_data_i;
            end
        end
    end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb/tb_cpu_mem_arbiter.sv - self-checking bench for cpu_mem_arbiter against a transaction-level model
module tb_cpu_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        f_req, f_flush, d_req, d_we, m_ack;
    logic [31:0] f_addr, d_addr, d_wdat, m_rdat;
    logic [3:0]  d_sel;
    logic        f_ack_o, d_ack_o, m_cyc_o, m_stb_o, m_we_o;
    logic [31:0] f_data_o, d_data_o, m_addr_o, m_data_o;
    logic [3:0]  m_sel_o;
    logic [1:0]  grant_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: who owns the bus, whether it is draining or responding, and the data streak.
    int          md_owner;
    bit          md_on_bus, md_drain, md_resp;
    int          md_streak;
    logic        e_fack, e_dack, e_cyc, e_stb, e_we;
    logic [3:0]  e_sel;
    logic [31:0] e_addr, e_wdat, e_fdata, e_ddata;
    logic [1:0]  e_grant;

    cpu_mem_arbiter #(.MAX_DATA_RUN(4)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .f_req_i(f_req), .f_addr_i(f_addr), .f_flush_i(f_flush),
        .f_ack_o(f_ack_o), .f_data_o(f_data_o),
        .d_req_i(d_req), .d_we_i(d_we), .d_sel_i(d_sel), .d_addr_i(d_addr),
        .d_data_i(d_wdat), .d_ack_o(d_ack_o), .d_data_o(d_data_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
        .m_addr_o(m_addr_o), .m_data_o(m_data_o), .m_data_i(m_rdat), .m_ack_i(m_ack),
        .grant_o(grant_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic bus_clear();
        e_cyc = 0; e_stb = 0; e_we = 0; e_sel = 0; e_addr = 0; e_wdat = 0;
    endtask

    task automatic model_reset();
        md_owner = 0; md_on_bus = 0; md_drain = 0; md_resp = 0; md_streak = 0;
        e_fack = 0; e_dack = 0; e_fdata = 0; e_ddata = 0; e_grant = 0;
        bus_clear();
    endtask

    task automatic model_step();
        e_fack = 0;
        e_dack = 0;
        if (md_resp) begin
            md_resp  = 0;
            md_owner = 0;
        end else if (!md_on_bus) begin
            if (d_req && (md_streak < 4 || !f_req)) begin
                md_owner = 2; md_on_bus = 1;
                e_cyc = 1; e_stb = 1; e_we = d_we; e_sel = d_sel; e_addr = d_addr; e_wdat = d_wdat;
                md_streak = f_req ? ((md_streak == 15) ? 15 : md_streak + 1) : 0;
            end else if (f_req && !f_flush) begin
                md_owner = 1; md_on_bus = 1;
                e_cyc = 1; e_stb = 1; e_we = 0; e_sel = 4'hF; e_addr = f_addr; e_wdat = 0;
                md_streak = 0;
            end else if (!f_req) begin
                md_streak = 0;
            end
        end else if (m_ack) begin
            bus_clear();
            md_on_bus = 0;
            if (md_drain) begin
                md_drain = 0;
                md_owner = 0;
            end else begin
                md_resp = 1;
                if (md_owner == 2) begin
                    e_dack = 1; e_ddata = m_rdat;
                end else begin
                    e_fack = !f_flush; e_fdata = m_rdat;
                end
            end
        end else if (md_owner == 1 && f_flush) begin
            md_drain = 1;
        end
        e_grant = 2'(md_owner);
    endtask

    task automatic compare_all();
        check("f_ack", 32'(f_ack_o), 32'(e_fack));
        check("d_ack", 32'(d_ack_o), 32'(e_dack));
        check("f_data", f_data_o, e_fdata);
        check("d_data", d_data_o, e_ddata);
        check("m_cyc", 32'(m_cyc_o), 32'(e_cyc));
        check("m_stb", 32'(m_stb_o), 32'(e_stb));
        check("m_we", 32'(m_we_o), 32'(e_we));
        check("m_sel", 32'(m_sel_o), 32'(e_sel));
        check("m_addr", m_addr_o, e_addr);
        check("m_wdata", m_data_o, e_wdat);
        check("grant", 32'(grant_o), 32'(e_grant));
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle_inputs();
        f_req = 0; f_flush = 0; d_req = 0; d_we = 0; m_ack = 0;
        f_addr = 0; d_addr = 0; d_wdat = 0; m_rdat = 0; d_sel = 0;
    endtask

    initial begin
        logic [1:0] seq_got [10];
        logic [1:0] seq_exp [10];
        int  n_seq;
        bit  prev_stb;
        bit  f_pend, d_pend;

        idle_inputs();
        rst_n = 0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst_n = 1;

        // fetch only, slave answers two cycles after the strobe
        f_req = 1; f_addr = 32'h0000_1000;
        step();
        check("fetch_addr", m_addr_o, 32'h0000_1000);
        check("fetch_sel", 32'(m_sel_o), 32'hF);
        step();
        step();
        m_ack = 1; m_rdat = 32'hDEAD_BEEF;
        step();
        check("fetch_ack", 32'(f_ack_o), 32'd1);
        check("fetch_rdata", f_data_o, 32'hDEAD_BEEF);
        m_ack = 0; f_req = 0;
        step();
        step();

        // both masters hammer a zero-wait bus: starvation guard lets fetch in every fifth grant
        seq_exp[0] = 2; seq_exp[1] = 2; seq_exp[2] = 2; seq_exp[3] = 2; seq_exp[4] = 1;
        seq_exp[5] = 2; seq_exp[6] = 2; seq_exp[7] = 2; seq_exp[8] = 2; seq_exp[9] = 1;
        n_seq = 0; prev_stb = 0;
        f_req = 1; f_addr = 32'h0000_0100; d_req = 1; d_addr = 32'h0000_0200; d_sel = 4'hF;
        for (int i = 0; i < 30; i++) begin
            m_ack = e_stb; m_rdat = 32'(i);
            step();
            if (m_stb_o && !prev_stb && n_seq < 10) begin
                seq_got[n_seq] = grant_o;
                n_seq++;
            end
            prev_stb = m_stb_o;
        end
        check("grant_seq_len", 32'(n_seq), 32'd10);
        for (int i = 0; i < 10; i++) check("grant_seq", 32'(seq_got[i]), 32'(seq_exp[i]));
        idle_inputs();
        step();
        step();

        // data write with partial byte lanes
        d_req = 1; d_we = 1; d_sel = 4'b0011; d_addr = 32'h0000_2004; d_wdat = 32'h1234_5678;
        step();
        check("dw_we", 32'(m_we_o), 32'd1);
        check("dw_sel", 32'(m_sel_o), 32'h3);
        check("dw_addr", m_addr_o, 32'h0000_2004);
        check("dw_wdata", m_data_o, 32'h1234_5678);
        m_ack = 1;
        step();
        check("dw_ack", 32'(d_ack_o), 32'd1);
        m_ack = 0; d_req = 0;
        step();
        check("dw_ack_single", 32'(d_ack_o), 32'd0);

        // flush one cycle after the strobe; slave answers three cycles later
        f_req = 1; f_addr = 32'h0000_3000;
        step();
        f_flush = 1;
        step();
        f_flush = 0; f_req = 0;
        step();
        check("discard_stb", 32'(m_stb_o), 32'd1);
        check("discard_grant", 32'(grant_o), 32'd1);
        step();
        m_ack = 1; m_rdat = 32'h5555_AAAA;
        step();
        check("discard_no_ack", 32'(f_ack_o), 32'd0);
        check("discard_idle_grant", 32'(grant_o), 32'd0);
        m_ack = 0;
        step();

        // flush arriving with the slave acknowledge
        f_req = 1; f_addr = 32'h0000_4000;
        step();
        m_ack = 1; f_flush = 1; m_rdat = 32'h0BAD_F00D;
        step();
        check("flush_ack_suppressed", 32'(f_ack_o), 32'd0);
        check("flush_resp_grant", 32'(grant_o), 32'd1);
        m_ack = 0; f_flush = 0; f_req = 0;
        step();

        // reset in the middle of a data transfer
        d_req = 1; d_we = 0; d_addr = 32'h0000_5000; d_sel = 4'hF;
        step();
        rst_n = 0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        idle_inputs();
        rst_n = 1;
        f_req = 1; f_addr = 32'h0000_6000;
        step();
        m_ack = 1; m_rdat = 32'hCAFE_0001;
        step();
        check("post_reset_fetch", f_data_o, 32'hCAFE_0001);
        m_ack = 0; f_req = 0;
        step();

        // randomized traffic
        f_pend = 0; d_pend = 0;
        for (int i = 0; i < 3000; i++) begin
            if (f_ack_o || f_flush) f_pend = 0;
            if (!f_pend && $urandom_range(0, 2) == 0) begin
                f_pend = 1;
                f_addr = $urandom() & 32'hFFFF_FFFC;
            end
            f_req   = f_pend;
            f_flush = ($urandom_range(0, 9) == 0);
            if (d_ack_o) d_pend = 0;
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1;
                d_we   = 1'($urandom_range(0, 1));
                d_sel  = 4'($urandom_range(0, 15));
                d_addr = $urandom();
                d_wdat = $urandom();
            end
            d_req  = d_pend;
            m_ack  = e_stb && ($urandom_range(0, 2) == 0);
            m_rdat = $urandom();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
